// File: rtl/axis_ofdm_frame_ctrl.sv
// axis_ofdm_frame_ctrl: OFDM frame sequencer (training symbol, N data symbols, gap, done).
// Define OFDM_FRAME_TRAIN_EN to include the training-symbol phase; without it frames start directly with data.
module axis_ofdm_frame_ctrl #(
    parameter int          SYM_LEN    = 64,
    parameter int          NSYM_W     = 8,
    parameter int          GAP_CYCLES = 16,
    parameter logic [31:0] TRAIN_WORD = 32'h4000_0000
) (
    input  logic              aclk,
    input  logic              aresetn,
    output logic              s_axis_tready,
    input  logic [31:0]       s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    input  logic              m_axis_tready,
    output logic [31:0]       m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              start,
    input  logic [NSYM_W-1:0] num_sym,
    output logic              mod_en,
    output logic              busy,
    output logic              done,
    output logic              sym_err
);
    localparam int KW = $clog2(SYM_LEN);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    if (TRAIN_WORD == '0 || (SYM_LEN & (SYM_LEN - 1)) != 0 || GAP_CYCLES < 1)
        $error("axis_ofdm_frame_ctrl: bad parameters");

`ifdef OFDM_FRAME_TRAIN_EN
    typedef enum logic [1:0] {S_IDLE, S_TRAIN, S_DATA, S_GAP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_GAP} state_t;
`endif

    state_t            state;
    logic [KW-1:0]     k;
    logic [NSYM_W-1:0] sym_cnt;
    logic [NSYM_W-1:0] num_lat;
    logic [GW-1:0]     gap_cnt;
    logic              k_last;
    logic              frame_last;
    logic              xfer;

    assign k_last     = k == KW'(SYM_LEN - 1);
    assign frame_last = k_last && sym_cnt == num_lat - NSYM_W'(1);

    // Stream muxing: zero-latency passthrough in data phase, generated symbol in training
    always_comb begin
        xfer          = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = 1'b0;
        if (state == S_DATA) begin
            m_axis_tvalid = s_axis_tvalid;
            m_axis_tdata  = s_axis_tdata;
            m_axis_tlast  = frame_last;
            s_axis_tready = m_axis_tready;
            xfer          = s_axis_tvalid & m_axis_tready;
        end
`ifdef OFDM_FRAME_TRAIN_EN
        else if (state == S_TRAIN) begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = (!k[0] && k != '0 && k != KW'(SYM_LEN / 2)) ? TRAIN_WORD : '0;
        end
`endif
    end

    // Frame FSM with word/symbol/gap counters and registered status outputs
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state   <= S_IDLE;
            k       <= '0;
            sym_cnt <= '0;
            num_lat <= '0;
            gap_cnt <= '0;
            mod_en  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sym_err <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start && num_sym != '0) begin
                    num_lat <= num_sym;
                    sym_err <= 1'b0;
                    k       <= '0;
                    sym_cnt <= '0;
                    busy    <= 1'b1;
`ifdef OFDM_FRAME_TRAIN_EN
                    state   <= S_TRAIN;
`else
                    state   <= S_DATA;
                    mod_en  <= 1'b1;
`endif
                end
`ifdef OFDM_FRAME_TRAIN_EN
                S_TRAIN: if (m_axis_tready) begin
                    k <= k + KW'(1);
                    if (k_last) begin
                        state  <= S_DATA;
                        mod_en <= 1'b1;
                    end
                end
`endif
                S_DATA: if (xfer) begin
                    k <= k + KW'(1);
                    if (s_axis_tlast != k_last) sym_err <= 1'b1;
                    if (k_last) sym_cnt <= sym_cnt + NSYM_W'(1);
                    if (frame_last) begin
                        state   <= S_GAP;
                        mod_en  <= 1'b0;
                        gap_cnt <= '0;
                    end
                end
                S_GAP: begin
                    gap_cnt <= gap_cnt + GW'(1);
                    if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_ofdm_frame_ctrl.sv
// tb_axis_ofdm_frame_ctrl: randomized bench with a frame-level reference model for axis_ofdm_frame_ctrl.
module tb_axis_ofdm_frame_ctrl;
    localparam int SYM_LEN = 64;
    localparam int GAP     = 16;
`ifdef OFDM_FRAME_TRAIN_EN
    localparam bit TRAIN = 1'b1;
`else
    localparam bit TRAIN = 1'b0;
`endif

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        s_axis_tready;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        m_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        start;
    logic [7:0]  num_sym;
    logic        mod_en;
    logic        busy;
    logic        done;
    logic        sym_err;

    axis_ofdm_frame_ctrl dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
        .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
        .start(start), .num_sym(num_sym), .mod_en(mod_en),
        .busy(busy), .done(done), .sym_err(sym_err)
    );

    always #5 aclk = ~aclk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: words/cycles remaining in each frame phase
    int mtr = 0, mdat = 0, mgap = 0, tot = 0;
    bit mdone = 0, serr = 0;
    // Modulator model and stimulus knobs
    bit pend = 0, was_rst = 0;
    int spos = 0, rdy_mode = 0, vprob = 100, err_at = -1;
    logic start_q = 1'b0, rst_q = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit midle();
        return mtr == 0 && mdat == 0 && mgap == 0;
    endfunction

    function automatic logic [31:0] twd(input int k);
        return (k % 2 == 0 && k != 0 && k != SYM_LEN / 2) ? 32'h4000_0000 : 32'h0;
    endfunction

    task automatic compare();
        chk("busy", 32'(busy), 32'(!midle()));
        chk("done", 32'(done), 32'(mdone));
        chk("mod_en", 32'(mod_en), 32'(mtr == 0 && mdat > 0));
        chk("sym_err", 32'(sym_err), 32'(serr));
        if (mtr > 0) begin
            chk("trn_valid", 32'(m_axis_tvalid), 32'(1));
            chk("trn_data", m_axis_tdata, twd(SYM_LEN - mtr));
            chk("trn_last", 32'(m_axis_tlast), 32'(0));
            chk("trn_sready", 32'(s_axis_tready), 32'(0));
        end else if (mdat > 0) begin
            chk("dat_valid", 32'(m_axis_tvalid), 32'(s_axis_tvalid));
            chk("dat_sready", 32'(s_axis_tready), 32'(m_axis_tready));
            if (s_axis_tvalid) begin
                chk("dat_data", m_axis_tdata, s_axis_tdata);
                chk("dat_last", 32'(m_axis_tlast), 32'(mdat == 1));
            end
        end else begin
            chk("idle_valid", 32'(m_axis_tvalid), 32'(0));
            chk("idle_sready", 32'(s_axis_tready), 32'(0));
            chk("idle_last", 32'(m_axis_tlast), 32'(0));
            if (midle()) chk("idle_data", m_axis_tdata, 32'h0);
        end
    endtask

    task automatic mstep();
        bit dn;
        dn = (mgap == 1);
        if (midle()) begin
            if (start && num_sym != 0) begin
                tot  = int'(num_sym) * SYM_LEN;
                mtr  = TRAIN ? SYM_LEN : 0;
                mdat = tot;
                serr = 0;
            end
        end else if (mtr > 0) begin
            if (m_axis_tready) mtr--;
        end else if (mdat > 0) begin
            if (s_axis_tvalid && m_axis_tready) begin
                if (s_axis_tlast != ((tot - mdat) % SYM_LEN == SYM_LEN - 1)) serr = 1;
                mdat--;
                if (mdat == 0) mgap = GAP;
            end
        end else begin
            mgap--;
        end
        mdone = dn;
    endtask

    task automatic tick();
        @(negedge aclk);
        aresetn = !rst_q;
        start = start_q;
        m_axis_tready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ~m_axis_tready : 1'($urandom_range(1));
        if (!mod_en) pend = 0;
        else if (!pend && $urandom_range(99) < vprob) begin
            pend = 1;
            s_axis_tdata = $urandom;
            s_axis_tlast = (spos == SYM_LEN - 1) || (tot - mdat == err_at);
        end
        s_axis_tvalid = pend;
        #1;
        if (aresetn || was_rst) compare();
        if (!aresetn) begin
            mtr = 0; mdat = 0; mgap = 0; mdone = 0; serr = 0;
            pend = 0; spos = 0;
        end else begin
            if (s_axis_tvalid && s_axis_tready) begin
                pend = 0;
                spos = (spos + 1) % SYM_LEN;
            end
            mstep();
        end
        was_rst = !aresetn;
    endtask

    task automatic run_to_idle(input int ra, input bit poke);
        for (int c = 0; !midle(); c++) begin
            if (c == 40000) begin
                chk("frame_timeout", 32'(busy), 32'(0));
                break;
            end
            rst_q   = ra >= 0 && mtr == 0 && mdat > 0 && tot - mdat == ra;
            start_q = poke && mtr == 0 && mdat > 0 && tot - mdat == 10;
            tick();
            rst_q   = 1'b0;
            start_q = 1'b0;
        end
    endtask

    task automatic frame(input int n, input int rm, input int vp, input int ea, input int ra, input bit poke);
        num_sym  = 8'(n);
        rdy_mode = rm;
        vprob    = vp;
        err_at   = ea;
        start_q  = 1'b1;
        tick();
        start_q  = 1'b0;
        run_to_idle(ra, poke);
        start_q  = poke;
        tick();
        start_q  = 1'b0;
        if (poke) begin
            run_to_idle(-1, 1'b0);
            tick();
        end
        repeat (2) tick();
    endtask

    initial begin
        aresetn = 1'b0;
        start = 1'b0;
        num_sym = '0;
        m_axis_tready = 1'b1;
        s_axis_tdata = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        repeat (3) tick();
        rst_q = 1'b0;
        repeat (2) tick();
        frame(2, 0, 100, -1, -1, 1'b0);
        num_sym = 8'd0;
        start_q = 1'b1;
        repeat (3) tick();
        start_q = 1'b0;
        repeat (2) tick();
        frame(3, 1, 70, -1, -1, 1'b0);
        frame(2, 2, 60, 62, -1, 1'b0);
        frame(1, 0, 100, -1, -1, 1'b0);
        frame(2, 0, 100, -1, 100, 1'b0);
        frame(2, 2, 80, -1, -1, 1'b0);
        frame(2, 1, 90, -1, -1, 1'b1);
        for (int i = 0; i < 4; i++)
            frame($urandom_range(3, 1), $urandom_range(2), $urandom_range(100, 40), -1, -1, 1'b0);
        frame(255, 0, 100, -1, -1, 1'b0);
        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
